pll_reset_seq: RTL and testbench
================================

# pll_reset_seq

Reset sequencer that sits directly downstream of the Artix-7 PLL wrapper. It runs on the free-running reference clock, drives the PLL's reset pin and consumes its asynchronous LOCKED output. It withholds the system reset until lock has been stable for a hold-off period. If lock is not achieved in time, or is lost later, it re-issues the PLL reset.

## Interface
- PLL_RST_CYCLES, 16, width of each PLL reset pulse in clk_i cycles (≥1)
- LOCK_TIMEOUT, 100000, cycles allowed in WAIT_LOCK before a retry (≥2); 1 ms at 100 MHz
- HOLDOFF_CYCLES, 1024, consecutive synchronized-lock cycles required before release (≥1)
- SYNC_STAGES, 2, flops in the pll_locked_i synchronizer (≥2)
- clk_i  in  1  reference clock (same net as the PLL CLKIN1), free-running
- rst_i  in  1  synchronous, active-high reset
- pll_locked_i  in  1  PLL LOCKED, asynchronous to clk_i
- soft_rst_i  in  1  synchronous request to restart the full sequence
- pll_rst_o  out  1  to PLL RST, active-high
- rst_o  out  1  system reset, active-high; consumers re-synchronize it per domain
- ready_o  out  1  high only in RUN
- retry_count_o  out  8  lock-timeout retries, saturating
- lock_loss_count_o  out  8  lock losses while in RUN, saturating

## Operation
- pll_locked_i passes through a SYNC_STAGES flop chain, giving locked_s; no other logic reads pll_locked_i.
- One counter, cnt, is sized to hold max(PLL_RST_CYCLES, LOCK_TIMEOUT, HOLDOFF_CYCLES)−1 and is zeroed on every state change.
- FSM states: PLL_RST, WAIT_LOCK, HOLDOFF, RUN.
- PLL_RST: advance to WAIT_LOCK when cnt==PLL_RST_CYCLES−1.
- WAIT_LOCK:
  - locked_s=1 → HOLDOFF.
  - Otherwise, cnt==LOCK_TIMEOUT−1 → PLL_RST and retry_count +1.
- HOLDOFF:
  - locked_s=0 → WAIT_LOCK; the timeout restarts and no counter is incremented.
  - Otherwise, cnt==HOLDOFF_CYCLES−1 → RUN.
- RUN: locked_s=0 → PLL_RST and lock_loss_count +1.
- soft_rst_i=1 in any state → PLL_RST with cnt=0 and no counter increment. It takes priority over every other transition, including a simultaneous lock loss.
- Outputs are registered and computed from next-state, so they change on the same edge as the state:
  - pll_rst_o = (state==PLL_RST)
  - rst_o = (state!=RUN)
  - ready_o = (state==RUN)
- Both counters saturate at 255 and never wrap.

## Timing
- While rst_i=1, on each edge:
  - state=PLL_RST, cnt=0, synchronizer cleared
  - pll_rst_o=1, rst_o=1, ready_o=0
  - both counters = 0
- After rst_i falls, pll_rst_o stays high for exactly PLL_RST_CYCLES edges.
- Lock acquisition: if edge k is the first to sample pll_locked_i=1 in WAIT_LOCK, then rst_o falls and ready_o rises after edge k+SYNC_STAGES+HOLDOFF_CYCLES.
- Lock loss in RUN: if edge k first samples pll_locked_i=0, then after edge k+SYNC_STAGES:
  - rst_o=1, ready_o=0, pll_rst_o=1
  - lock_loss_count has been incremented
- Timeout: pll_rst_o reasserts LOCK_TIMEOUT edges after entering WAIT_LOCK.
- A lock glitch shorter than one clk_i period may or may not be captured; either outcome is legal.
- rst_i asserted mid-sequence overrides every state on the next edge.

## Configuration
- Macro: PLL_RESET_SEQ_STATS_EN.
- Defined: retry_count_o and lock_loss_count_o are implemented as specified.
- Undefined: both counter registers are absent, both outputs are tied to 8'd0, and FSM behaviour is identical.

## Test plan
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, HOLDOFF_CYCLES=8, SYNC_STAGES=2.
- Basic lock:
  - Stimulus: release rst_i; raise pll_locked_i 3 cycles after pll_rst_o falls.
  - Required: pll_rst_o high for 4 cycles after release; rst_o falls 10 edges after the first locked sample; ready_o=1; counters 0.
- Timeout retry:
  - Stimulus: hold pll_locked_i=0 for 50 cycles.
  - Required: pll_rst_o pulses (4 cycles each) begin 20 cycles after each WAIT_LOCK entry; retry_count_o=2; rst_o stays 1.
- Hold-off abort:
  - Stimulus: lock for 5 cycles, drop for 1, then hold lock.
  - Required: no pll_rst_o pulse; the full 8-cycle hold-off restarts; counters 0; RUN is reached.
- Lock loss in RUN:
  - Stimulus: drop pll_locked_i.
  - Required: after 2 edges, rst_o=1, pll_rst_o=1, lock_loss_count_o=1.
  - Repeating this 300 times saturates the count at 255.
- soft_rst_i coincident with lock loss:
  - Required: state goes to PLL_RST; lock_loss_count_o unchanged.
- rst_i pulsed in HOLDOFF:
  - Required: next edge gives pll_rst_o=1, rst_o=1, counters 0.
  - Repeat with PLL_RESET_SEQ_STATS_EN undefined: counters read 0 throughout.

Source files
------------

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: reset sequencer downstream of the PLL wrapper.
// Pulses the PLL reset, waits for a synchronized LOCKED, holds the system
// reset through a hold-off window, and re-issues the PLL reset on lock
// timeout or lock loss.
// Optional feature: define PLL_RESET_SEQ_STATS_EN to implement the saturating
// retry / lock-loss counters; otherwise both count outputs read 8'd0.
module pll_reset_seq #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 100000,
  parameter int unsigned HOLDOFF_CYCLES = 1024,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  input  logic       soft_rst_i,
  output logic       pll_rst_o,
  output logic       rst_o,
  output logic       ready_o,
  output logic [7:0] retry_count_o,
  output logic [7:0] lock_loss_count_o
);

  // One shared counter must reach the largest terminal value minus one.
  localparam int unsigned MaxAb  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES
                                                                   : LOCK_TIMEOUT;
  localparam int unsigned CntLen = (MaxAb > HOLDOFF_CYCLES) ? MaxAb : HOLDOFF_CYCLES;
  localparam int unsigned CntW   = (CntLen > 1) ? $clog2(CntLen) : 1;

  localparam logic [CntW-1:0] PllRstLast  = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] HoldoffLast = CntW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    StPllRst,
    StWaitLock,
    StHoldoff,
    StRun
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   cnt_clr;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  // LOCKED is asynchronous; only the last synchronizer stage is ever used.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Next-state selection; soft reset overrides every other transition.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    if (soft_rst_i) begin
      state_d = StPllRst;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        StPllRst: begin
          if (cnt_q == PllRstLast) state_d = StWaitLock;
        end
        StWaitLock: begin
          if (locked_s)                  state_d = StHoldoff;
          else if (cnt_q == TimeoutLast) state_d = StPllRst;
        end
        StHoldoff: begin
          if (!locked_s)                 state_d = StWaitLock;
          else if (cnt_q == HoldoffLast) state_d = StRun;
        end
        StRun: begin
          if (!locked_s) state_d = StPllRst;
        end
        default: state_d = StPllRst;
      endcase
    end
    if (state_d != state_q) cnt_clr = 1'b1;
  end

  // RUN has no timed exit, so the counter is parked there.
  assign cnt_d = cnt_clr            ? '0    :
                 (state_q == StRun) ? cnt_q :
                                      cnt_q + CntW'(1);

  // State, counter and registered outputs decoded from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StPllRst;
      cnt_q     <= '0;
      pll_rst_o <= 1'b1;
      rst_o     <= 1'b1;
      ready_o   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst_o <= (state_d == StPllRst);
      rst_o     <= (state_d != StRun);
      ready_o   <= (state_d == StRun);
    end
  end

`ifdef PLL_RESET_SEQ_STATS_EN
  logic       retry_inc, loss_inc;
  logic [7:0] retry_q, loss_q;

  assign retry_inc = !soft_rst_i && (state_q == StWaitLock) && !locked_s &&
                     (cnt_q == TimeoutLast);
  assign loss_inc  = !soft_rst_i && (state_q == StRun) && !locked_s;

  // Saturating event counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retry_q <= 8'd0;
      loss_q  <= 8'd0;
    end else begin
      if (retry_inc && (retry_q != 8'hff)) retry_q <= retry_q + 8'd1;
      if (loss_inc && (loss_q != 8'hff))   loss_q  <= loss_q + 8'd1;
    end
  end

  assign retry_count_o     = retry_q;
  assign lock_loss_count_o = loss_q;
`else
  assign retry_count_o     = 8'd0;
  assign lock_loss_count_o = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: per-cycle reference model feeding a scoreboard queue,
// plus directed latency / counter checks for each scenario.
module tb_pll_reset_seq;

  localparam int PR = 4;
  localparam int LT = 20;
  localparam int HO = 8;
  localparam int SS = 2;
`ifdef PLL_RESET_SEQ_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic       soft_rst;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [7:0] retry_cnt;
  logic [7:0] loss_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pll_reset_seq #(
    .PLL_RST_CYCLES(PR),
    .LOCK_TIMEOUT  (LT),
    .HOLDOFF_CYCLES(HO),
    .SYNC_STAGES   (SS)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .pll_locked_i     (pll_locked),
    .soft_rst_i       (soft_rst),
    .pll_rst_o        (pll_rst),
    .rst_o            (sys_rst),
    .ready_o          (ready),
    .retry_count_o    (retry_cnt),
    .lock_loss_count_o(loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: 0 PLL reset, 1 wait lock, 2 hold-off, 3 run.
  int         m_state;
  int         m_time;   // edges spent in the current state
  logic [SS-1:0] m_sync;
  int         m_retry;
  int         m_loss;
  logic [18:0] exp_q[$];

  always @(posedge clk) begin
    int  nxt;
    bit  ls;
    if (rst) begin
      m_state = 0;
      m_time  = 0;
      m_sync  = '0;
      m_retry = 0;
      m_loss  = 0;
    end else begin
      ls     = m_sync[SS-1];
      m_sync = {m_sync[SS-2:0], pll_locked};
      nxt    = m_state;
      if (soft_rst) begin
        nxt = 0;
      end else if (m_state == 0) begin
        if (m_time == PR - 1) nxt = 1;
      end else if (m_state == 1) begin
        if (ls) nxt = 2;
        else if (m_time == LT - 1) begin
          nxt = 0;
          if (Stats && m_retry < 255) m_retry++;
        end
      end else if (m_state == 2) begin
        if (!ls) nxt = 1;
        else if (m_time == HO - 1) nxt = 3;
      end else begin
        if (!ls) begin
          nxt = 0;
          if (Stats && m_loss < 255) m_loss++;
        end
      end
      if (soft_rst || nxt != m_state) m_time = 0;
      else m_time++;
      m_state = nxt;
    end
    exp_q.push_back({m_state == 0, m_state != 3, m_state == 3,
                     m_retry[7:0], m_loss[7:0]});
  end

  // Scoreboard: compare each registered output set half a cycle later.
  always @(negedge clk) begin
    logic [18:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle", {13'b0, pll_rst, sys_rst, ready, retry_cnt, loss_cnt}, {13'b0, e});
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  // Edges until ready_o rises, bounded.
  task automatic edges_to_ready(output int n, output bit saw_pll_rst);
    n = 0;
    saw_pll_rst = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (pll_rst) saw_pll_rst = 1'b1;
    end while (!ready && n < 200);
  endtask

  task automatic wait_pll_rst_low(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pll_rst && n < 200);
  endtask

  initial begin
    int n;
    int fall_i;
    bit saw;
    bit bad;
    bit prev;

    rst = 1'b1;
    soft_rst = 1'b0;
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pll_rst", pll_rst, 1);
    check("reset_rst", sys_rst, 1);
    check("reset_ready", ready, 0);
    check("reset_retry", retry_cnt, 0);
    check("reset_loss", loss_cnt, 0);

    // Basic lock.
    rst = 1'b0;
    wait_pll_rst_low(n);
    check("pll_rst_width", n, PR);
    repeat (3) @(negedge clk);
    pll_locked = 1'b1;
    edges_to_ready(n, saw);
    check("lock_latency", n, 1 + SS + HO);
    check("lock_rst_low", sys_rst, 0);
    check("lock_retry", retry_cnt, 0);
    check("lock_loss", loss_cnt, 0);

    // Lock loss in RUN.
    pll_locked = 1'b0;
    repeat (2) @(negedge clk);
    check("loss_not_yet", sys_rst, 0);
    @(negedge clk);
    check("loss_rst", sys_rst, 1);
    check("loss_pll_rst", pll_rst, 1);
    check("loss_count", loss_cnt, Stats ? 1 : 0);

    // Soft reset on the same edge the lock loss is seen.
    pll_locked = 1'b1;
    edges_to_ready(n, saw);
    check("relock_ready", ready, 1);
    pll_locked = 1'b0;
    repeat (2) @(negedge clk);
    soft_rst = 1'b1;
    @(negedge clk);
    soft_rst = 1'b0;
    check("soft_pll_rst", pll_rst, 1);
    check("soft_rst_o", sys_rst, 1);
    check("soft_loss_same", loss_cnt, Stats ? 1 : 0);

    // Timeout retry.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    prev = 1'b1;
    fall_i = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (!sys_rst) bad = 1'b1;
      if (prev && !pll_rst) fall_i = i;
      if (!prev && pll_rst) check("timeout_spacing", i - fall_i, LT);
      prev = pll_rst;
    end
    check("timeout_rst_held", bad, 0);
    check("timeout_retry", retry_cnt, Stats ? 2 : 0);

    // Hold-off abort: lock 5 cycles, drop 1, relock.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_pll_rst_low(n);
    pll_locked = 1'b1;
    repeat (5) @(negedge clk);
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    edges_to_ready(n, saw);
    check("abort_latency", n, 1 + SS + HO);
    check("abort_no_pll_rst", saw, 0);
    check("abort_retry", retry_cnt, 0);
    check("abort_loss", loss_cnt, 0);

    // 300 lock losses saturate the counter.
    bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      repeat (3) @(negedge clk);
      pll_locked = 1'b1;
      edges_to_ready(n, saw);
      if (!ready) bad = 1'b1;
    end
    check("sat_all_relocked", bad, 0);
    check("sat_loss", loss_cnt, Stats ? 255 : 0);

    // rst_i pulsed during hold-off.
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    pll_locked = 1'b1;
    wait_pll_rst_low(n);
    repeat (2) @(negedge clk);
    check("holdoff_reached", sys_rst, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("hrst_pll_rst", pll_rst, 1);
    check("hrst_rst", sys_rst, 1);
    check("hrst_ready", ready, 0);
    check("hrst_retry", retry_cnt, 0);
    check("hrst_loss", loss_cnt, 0);
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
